// File: rtl/nand_seq_ctrl.sv
// nand_seq_ctrl: sequences one shared bitwise NAND resource to evaluate eight logic functions
module nand_seq_ctrl #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic [WIDTH-1:0] nand_a,
    output logic [WIDTH-1:0] nand_b,
    input  logic [WIDTH-1:0] nand_y
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam logic [2:0] SA = 3'd0, SB = 3'd1, S1 = 3'd2, S2 = 3'd3, S3 = 3'd4;
    localparam logic [1:0] D1 = 2'd0, D2 = 2'd1, D3 = 2'd2, DY = 2'd3;
    state_t state_q, state_d;
    logic [2:0] step_q, step_d, op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, y_q, y_d;
    logic [2:0] sa, sb;
    logic [1:0] dst;
    logic last;
    logic [WIDTH-1:0] op_a, op_b;
    // micro-program ROM: operand sources, destination and last-step flag for each (op, step)
    always_comb begin
        {sa, sb, dst, last} = {SA, SA, DY, 1'b1};
        case ({op_q, step_q})
            6'o00: {sa, sb, dst, last} = {SA, SB, DY, 1'b1};
            6'o10, 6'o40, 6'o50: {sa, sb, dst, last} = {SA, SB, D1, 1'b0};
            6'o11, 6'o71: {sa, sb, dst, last} = {S1, S1, DY, 1'b1};
            6'o20, 6'o30, 6'o70: {sa, sb, dst, last} = {SA, SA, D1, 1'b0};
            6'o21, 6'o31: {sa, sb, dst, last} = {SB, SB, D2, 1'b0};
            6'o22: {sa, sb, dst, last} = {S1, S2, DY, 1'b1};
            6'o32: {sa, sb, dst, last} = {S1, S2, D3, 1'b0};
            6'o33: {sa, sb, dst, last} = {S3, S3, DY, 1'b1};
            6'o41, 6'o51: {sa, sb, dst, last} = {SA, S1, D2, 1'b0};
            6'o42, 6'o52: {sa, sb, dst, last} = {SB, S1, D3, 1'b0};
            6'o43: {sa, sb, dst, last} = {S2, S3, DY, 1'b1};
            6'o53: {sa, sb, dst, last} = {S2, S3, D1, 1'b0};
            6'o54: {sa, sb, dst, last} = {S1, S1, DY, 1'b1};
            6'o60: {sa, sb, dst, last} = {SA, SA, DY, 1'b1};
            default: {sa, sb, dst, last} = {SA, SA, DY, 1'b1};
        endcase
    end
    assign op_a = sa == SA ? a_q : sa == SB ? b_q : sa == S1 ? t1_q : sa == S2 ? t2_q : t3_q;
    assign op_b = sb == SA ? a_q : sb == SB ? b_q : sb == S1 ? t1_q : sb == S2 ? t2_q : t3_q;
    assign in_ready  = rst_n && state_q == IDLE;
    assign out_valid = rst_n && state_q == DONE;
    assign busy      = rst_n && state_q == EXEC;
    assign nand_a    = busy ? op_a : '0;
    assign nand_b    = busy ? op_b : '0;
    assign y         = y_q;
    // handshake FSM and step execution: capture the NAND result into the step's destination
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        t3_d    = t3_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = EXEC;
                step_d  = '0;
                a_d     = a;
                b_d     = b;
                op_d    = op;
            end
            EXEC: begin
                t1_d    = dst == D1 ? nand_y : t1_q;
                t2_d    = dst == D2 ? nand_y : t2_q;
                t3_d    = dst == D3 ? nand_y : t3_q;
                y_d     = dst == DY ? nand_y : y_q;
                state_d = last ? DONE : EXEC;
                step_d  = last ? step_q : step_q + 3'd1;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            y_q     <= y_d;
        end
    end
endmodule

// File: tb/tb_nand_seq_ctrl.sv
// tb_nand_seq_ctrl: randomized and directed checks of 1-bit and 8-bit sequencers against a truth-table model
module tb_nand_seq_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0;
    logic out_ready = 1;
    logic [2:0] op = 0;
    logic [7:0] a = 0, b = 0;
    logic in_ready1, out_valid1, busy1;
    logic [0:0] y1, nand_a1, nand_b1, nand_y1;
    logic in_ready8, out_valid8, busy8;
    logic [7:0] y8, nand_a8, nand_b8, nand_y8;
    int tests = 0;
    int fails = 0;
    int lat_tab[8] = '{1, 2, 3, 4, 4, 5, 1, 2};

    always #5 clk = ~clk;

    assign nand_y1 = ~(nand_a1 & nand_b1);
    assign nand_y8 = ~(nand_a8 & nand_b8);

    nand_seq_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a[0]), .b(b[0]), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
        .y(y1), .busy(busy1), .nand_a(nand_a1), .nand_b(nand_b1), .nand_y(nand_y1)
    );

    nand_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .op(op), .out_valid(out_valid8), .out_ready(out_ready),
        .y(y8), .busy(busy8), .nand_a(nand_a8), .nand_b(nand_b8), .nand_y(nand_y8)
    );

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0: return ~(x & z);
            3'd1: return x & z;
            3'd2: return x | z;
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic run(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv, input int stall);
        logic [7:0] e;
        int cnt;
        e = model(o, av, bv);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1; out_ready = (stall == 0);
        tests++;
        if (in_ready1 !== 1'b1 || in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL accept_ready op=%0d got %b/%b want 1/1", o, in_ready1, in_ready8);
        end
        @(posedge clk); #1;
        in_valid = 0;
        cnt = 0;
        while (out_valid1 !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        tests++;
        if (cnt != lat_tab[o]) begin
            fails++;
            $display("FAIL latency op=%0d got %0d want %0d", o, cnt, lat_tab[o]);
        end
        tests++;
        if (y1 !== e[0]) begin
            fails++;
            $display("FAIL y_w1 op=%0d a=%b b=%b got %b want %b", o, av[0], bv[0], y1, e[0]);
        end
        tests++;
        if (y8 !== e || out_valid8 !== 1'b1) begin
            fails++;
            $display("FAIL y_w8 op=%0d a=%h b=%h got %h/%b want %h/1", o, av, bv, y8, out_valid8, e);
        end
        repeat (stall) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid1 !== 1'b1 || out_valid8 !== 1'b1 || y8 !== e) begin
                fails++;
                $display("FAIL hold op=%0d got %b/%b y=%h want 1/1 y=%h", o, out_valid1, out_valid8, y8, e);
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        tests++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            fails++;
            $display("FAIL handoff op=%0d got rdy=%b/%b ov=%b/%b want 1/1 0/0", o, in_ready1, in_ready8, out_valid1, out_valid8);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold got rdy=%b ov=%b rdy8=%b want 0 0 0", in_ready1, out_valid1, in_ready8);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        tests++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 || y1 !== 1'b0 || nand_a1 !== 1'b0 || nand_b1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_w1 got rdy=%b ov=%b busy=%b y=%b na=%b nb=%b want 1 0 0 0 0 0", in_ready1, out_valid1, busy1, y1, nand_a1, nand_b1);
        end
        tests++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 8'h00 || nand_a8 !== 8'h00 || nand_b8 !== 8'h00) begin
            fails++;
            $display("FAIL reset_w8 got rdy=%b ov=%b busy=%b y=%h na=%h nb=%h want 1 0 0 00 00 00", in_ready8, out_valid8, busy8, y8, nand_a8, nand_b8);
        end
    endtask

    task automatic test_exhaustive();
        for (int o = 0; o < 8; o++)
            for (int ab = 0; ab < 4; ab++)
                run(3'(o), {7'($urandom), 1'(ab >> 1)}, {7'($urandom), 1'(ab)}, 0);
    endtask

    task automatic test_micro_probe();
        logic [3:0] ea = 4'b1111;
        logic [3:0] eb = 4'b1001;
        @(negedge clk);
        op = 3'd4; a = 8'h01; b = 8'h01; in_valid = 1;
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1;
            in_valid = 0;
            tests++;
            if (nand_a1 !== ea[3-s] || nand_b1 !== eb[3-s] || busy1 !== 1'b1) begin
                fails++;
                $display("FAIL probe step%0d got (%b,%b) busy=%b want (%b,%b) busy=1", s, nand_a1, nand_b1, busy1, ea[3-s], eb[3-s]);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (y1 !== 1'b0 || out_valid1 !== 1'b1 || nand_a1 !== 1'b0 || nand_b1 !== 1'b0) begin
            fails++;
            $display("FAIL probe_done got y=%b ov=%b na=%b nb=%b want 0 1 0 0", y1, out_valid1, nand_a1, nand_b1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cnt = 0;
        @(negedge clk);
        op = 3'd2; a = 8'h00; b = 8'h01; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        while (out_valid1 !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        repeat (5) begin
            @(negedge clk);
            in_valid = 1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            in_valid = 0;
            tests++;
            if (out_valid1 !== 1'b1 || y1 !== 1'b1 || in_ready1 !== 1'b0 || y8 !== 8'h01) begin
                fails++;
                $display("FAIL backpressure got ov=%b y=%b rdy=%b y8=%h want 1 1 0 01", out_valid1, y1, in_ready1, y8);
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        tests++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || y1 !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got rdy=%b ov=%b y=%b want 1 0 1", in_ready1, out_valid1, y1);
        end
        @(posedge clk); #1;
        tests++;
        if (busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL bp_ignored got busy=%b rdy=%b want 0 1", busy1, in_ready1);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen = 0;
        @(negedge clk);
        op = 3'd5; a = 8'h01; b = 8'h00; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid1 === 1'b1 || busy1 === 1'b1) seen = 1;
        end
        tests++;
        if (seen || in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_abort got seen=%b rdy=%b want 0 1", seen, in_ready1);
        end
        run(3'd0, 8'h01, 8'h01, 0);
    endtask

    task automatic test_wide();
        run(3'd4, 8'hF0, 8'h3C, 0);
        tests++;
        if (y8 !== 8'hCC) begin
            fails++;
            $display("FAIL wide_xor got %h want cc", y8);
        end
        run(3'd3, 8'hF0, 8'h3C, 0);
        tests++;
        if (y8 !== 8'h03) begin
            fails++;
            $display("FAIL wide_nor got %h want 03", y8);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_micro_probe();
        test_backpressure();
        test_reset_mid_op();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
